// File: rtl/angle_pkg.sv
// angle_pkg: shared constants, FSM state type and quarter-wave sine
// generator for the look-direction pipeline.
//   W         signed width of angle inputs and vector outputs
//   SCALE     unit-vector magnitude (LUT scale and divisor)
//   TURN      angle units per full revolution (must be a multiple of 4)
//   PITCH_MAX pitch clamp magnitude, below TURN/4
package angle_pkg;

    localparam int W         = 20;
    localparam int SCALE     = 225;
    localparam int TURN      = 360;
    localparam int PITCH_MAX = 89;

    // Bits needed for the magnitude of a product of two trig values.
    localparam int PW   = 2 * $clog2(SCALE + 1);
    // Signed width of one trig value (magnitude up to SCALE).
    localparam int TW   = PW / 2 + 1;
    // Divider: shifted partial remainder width, stored remainder width.
    localparam int RW   = PW / 2 + 1;
    localparam int RMW  = RW - 1;
    localparam int IW   = $clog2(TURN);
    localparam int Q    = TURN / 4;
    localparam int QIW  = $clog2(Q + 1);
    localparam int QN   = 2 ** QIW;
    localparam int CW   = $clog2(PW);
    localparam int LAT  = 4 + 2 * PW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRAP   = 3'd1,
        LOOKUP = 3'd2,
        MUL_X  = 3'd3,
        DIV_X  = 3'd4,
        MUL_Y  = 3'd5,
        DIV_Y  = 3'd6,
        DONE   = 3'd7
    } state_t;

    // round(SCALE * sin(i * 2*pi / TURN)) for 0 <= i <= TURN/4, evaluated at
    // elaboration only. Values here are never negative, so adding one half
    // rounds half away from zero; the small bias keeps exact halves such as
    // SCALE*sin(30 deg) from falling just short through float error.
    function automatic int sin_quarter(input int i);
        real x;
        real term;
        real sum;
        x    = $itor(i) * 2.0 * 3.14159265358979323846 / $itor(TURN);
        term = x;
        sum  = x;
        for (int k = 1; k < 14; k++) begin
            term = -term * x * x / ($itor(2 * k) * $itor(2 * k + 1));
            sum  = sum + term;
        end
        return $rtoi($itor(SCALE) * sum + 0.5 + 1.0e-6);
    endfunction

endpackage

// File: rtl/angle_sincos.sv
// angle_sincos: combinational cos/sin lookup at SCALE.
//   idx     in  IW  angle index, 0 <= idx < TURN
//   cos_v   out TW  signed round(SCALE*cos)
//   sin_v   out TW  signed round(SCALE*sin)
// Only a quarter-wave table is stored; quadrant symmetry gives the rest.
module angle_sincos
    import angle_pkg::*;
(
    input  logic [IW-1:0]        idx,
    output logic signed [TW-1:0] cos_v,
    output logic signed [TW-1:0] sin_v
);

    localparam logic [IW-1:0]  Q1 = IW'(Q);
    localparam logic [IW-1:0]  Q2 = IW'(2 * Q);
    localparam logic [IW-1:0]  Q3 = IW'(3 * Q);
    localparam logic [QIW-1:0] QQ = QIW'(Q);

    logic signed [TW-1:0] tbl [0:QN-1];

    for (genvar i = 0; i < QN; i++) begin : g_tbl
        localparam int V = (i <= Q) ? sin_quarter(i) : 0;
        assign tbl[i] = TW'(V);
    end

    logic [1:0]           quad;
    logic [QIW-1:0]       r;
    logic [QIW-1:0]       qr;
    logic signed [TW-1:0] a;
    logic signed [TW-1:0] b;

    always_comb begin
        quad = 2'd0;
        r    = QIW'(idx);
        if (idx < Q1) begin
            quad = 2'd0;
            r    = QIW'(idx);
        end else if (idx < Q2) begin
            quad = 2'd1;
            r    = QIW'(idx - Q1);
        end else if (idx < Q3) begin
            quad = 2'd2;
            r    = QIW'(idx - Q2);
        end else begin
            quad = 2'd3;
            r    = QIW'(idx - Q3);
        end
        qr = QQ - r;
        a  = tbl[r];
        b  = tbl[qr];
        case (quad)
            2'd0:    begin sin_v = a;  cos_v = b;  end
            2'd1:    begin sin_v = b;  cos_v = -a; end
            2'd2:    begin sin_v = -a; cos_v = -b; end
            default: begin sin_v = -b; cos_v = a;  end
        endcase
    end

endmodule

// File: rtl/angle_relative_pipe.sv
// angle_relative_pipe: yaw/pitch -> scaled 3-D and horizontal look vectors.
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid/in_ready        request handshake (angle_x yaw, angle_y pitch)
//   out_valid/out_ready      result handshake
//   lookat_rel_x/y/z         3-D look vector
//   lookat_h_rel_x/y         horizontal look vector
//   range_err                result came from an out-of-range yaw
//   state_dbg                current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and out_valid with its data is
// held until out_ready takes it.
// One multiplier and one restoring divider are shared by the two products.
module angle_relative_pipe
    import angle_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] angle_x,
    input  logic signed [W-1:0] angle_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] lookat_rel_x,
    output logic signed [W-1:0] lookat_rel_y,
    output logic signed [W-1:0] lookat_rel_z,
    output logic signed [W-1:0] lookat_h_rel_x,
    output logic signed [W-1:0] lookat_h_rel_y,
    output logic                range_err,
    output state_t              state_dbg
);

    localparam logic signed [W-1:0] TURN_S  = W'(TURN);
    localparam logic signed [W-1:0] TURN2_S = W'(2 * TURN);
    localparam logic signed [W-1:0] NTURN_S = -W'(TURN);
    localparam logic signed [W-1:0] PMAX_S  = W'(PITCH_MAX);
    localparam logic signed [W-1:0] NPMAX_S = -W'(PITCH_MAX);

    state_t state, state_next;

    logic                 ready_en;
    logic signed [W-1:0]  ax, ay;
    logic [IW-1:0]        yaw_idx, pit_idx;
    logic                 err;
    logic signed [TW-1:0] hc, hs, vc, vs;
    logic signed [TW-1:0] yaw_cos, yaw_sin, pit_cos, pit_sin;
    logic                 neg;
    logic [PW-1:0]        mag, quo;
    logic [RMW-1:0]       rem;
    logic [CW-1:0]        cnt;
    logic signed [W-1:0]  res_x;

    assign state_dbg = state;
    assign in_ready  = ready_en && (state == IDLE);

    wire accept   = in_valid && in_ready;
    wire div_last = (cnt == CW'(PW - 1));

    angle_sincos u_yaw (.idx(yaw_idx), .cos_v(yaw_cos), .sin_v(yaw_sin));
    angle_sincos u_pit (.idx(pit_idx), .cos_v(pit_cos), .sin_v(pit_sin));

    // Range check, yaw wrap and pitch clamp on the registered angles.
    logic signed [W-1:0] yaw_w, pit_c, pit_w;
    logic                err_c;
    always_comb begin
        yaw_w = '0;
        err_c = 1'b0;
        if (!ax[W-1] && ax < TURN_S)          yaw_w = ax;
        else if (ax[W-1] && ax >= NTURN_S)    yaw_w = ax + TURN_S;
        else if (ax >= TURN_S && ax < TURN2_S) yaw_w = ax - TURN_S;
        else                                  err_c = 1'b1;
        if (ay > PMAX_S)       pit_c = PMAX_S;
        else if (ay < NPMAX_S) pit_c = NPMAX_S;
        else                   pit_c = ay;
        pit_w = pit_c[W-1] ? pit_c + TURN_S : pit_c;
    end

    // Shared multiplier: hc*vc in MUL_X, hs*vc in MUL_Y.
    logic signed [TW-1:0] mul_a;
    logic signed [PW+1:0] prod;
    logic [PW+1:0]        prod_abs;
    always_comb begin
        mul_a    = (state == MUL_Y) ? hs : hc;
        prod     = mul_a * vc;
        prod_abs = prod[PW+1] ? -prod : prod;
    end

    // One restoring-divide step; div_res is the signed quotient that this
    // step completes when it is the last one.
    logic [RW-1:0]       r_sh, r_nx;
    logic                ge;
    logic [PW-1:0]       q_nx;
    logic signed [W-1:0] q_ext, div_res;
    always_comb begin
        r_sh    = {rem, mag[PW-1]};
        ge      = (r_sh >= RW'(SCALE));
        r_nx    = ge ? r_sh - RW'(SCALE) : r_sh;
        q_nx    = {quo[PW-2:0], ge};
        q_ext   = {{(W-PW){1'b0}}, q_nx};
        div_res = neg ? -q_ext : q_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WRAP;
            WRAP:    state_next = LOOKUP;
            // The range flag registered in WRAP is acted on here.
            LOOKUP:  state_next = err ? DONE : MUL_X;
            MUL_X:   state_next = DIV_X;
            DIV_X:   if (div_last) state_next = MUL_Y;
            MUL_Y:   state_next = DIV_Y;
            DIV_Y:   if (div_last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en       <= 1'b0;
            ax             <= '0;
            ay             <= '0;
            yaw_idx        <= '0;
            pit_idx        <= '0;
            err            <= 1'b0;
            hc             <= '0;
            hs             <= '0;
            vc             <= '0;
            vs             <= '0;
            neg            <= 1'b0;
            mag            <= '0;
            quo            <= '0;
            rem            <= '0;
            cnt            <= '0;
            res_x          <= '0;
            out_valid      <= 1'b0;
            range_err      <= 1'b0;
            lookat_rel_x   <= '0;
            lookat_rel_y   <= '0;
            lookat_rel_z   <= '0;
            lookat_h_rel_x <= '0;
            lookat_h_rel_y <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    ax <= angle_x;
                    ay <= angle_y;
                end
                WRAP: begin
                    yaw_idx <= IW'(yaw_w);
                    pit_idx <= IW'(pit_w);
                    err     <= err_c;
                end
                LOOKUP: begin
                    hc <= yaw_cos;
                    hs <= yaw_sin;
                    vc <= pit_cos;
                    vs <= pit_sin;
                    if (err) begin
                        lookat_rel_x   <= '0;
                        lookat_rel_y   <= '0;
                        lookat_rel_z   <= '0;
                        lookat_h_rel_x <= '0;
                        lookat_h_rel_y <= '0;
                        range_err      <= 1'b1;
                        out_valid      <= 1'b1;
                    end
                end
                MUL_X, MUL_Y: begin
                    neg <= prod[PW+1];
                    mag <= PW'(prod_abs);
                    quo <= '0;
                    rem <= '0;
                    cnt <= '0;
                end
                DIV_X, DIV_Y: begin
                    mag <= {mag[PW-2:0], 1'b0};
                    rem <= RMW'(r_nx);
                    quo <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (div_last && state == DIV_X) res_x <= div_res;
                    if (div_last && state == DIV_Y) begin
                        lookat_rel_x   <= res_x;
                        lookat_rel_y   <= div_res;
                        lookat_rel_z   <= {{(W-TW){vs[TW-1]}}, vs};
                        lookat_h_rel_x <= {{(W-TW){hc[TW-1]}}, hc};
                        lookat_h_rel_y <= {{(W-TW){hs[TW-1]}}, hs};
                        range_err      <= 1'b0;
                        out_valid      <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_relative_pipe.sv
module tb_angle_relative_pipe;
    import angle_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] angle_x;
    logic signed [W-1:0] angle_y;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] lookat_rel_x, lookat_rel_y, lookat_rel_z;
    logic signed [W-1:0] lookat_h_rel_x, lookat_h_rel_y;
    logic                range_err;
    state_t              state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    angle_relative_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .angle_x        (angle_x),
        .angle_y        (angle_y),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .lookat_rel_x   (lookat_rel_x),
        .lookat_rel_y   (lookat_rel_y),
        .lookat_rel_z   (lookat_rel_z),
        .lookat_h_rel_x (lookat_h_rel_x),
        .lookat_h_rel_y (lookat_h_rel_y),
        .range_err      (range_err),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input int ex, input int ey, input int ez,
                           input int ehx, input int ehy, input int eerr);
        chk("rel_x", int'(lookat_rel_x), ex);
        chk("rel_y", int'(lookat_rel_y), ey);
        chk("rel_z", int'(lookat_rel_z), ez);
        chk("h_rel_x", int'(lookat_h_rel_x), ehx);
        chk("h_rel_y", int'(lookat_h_rel_y), ehy);
        chk("range_err", int'(range_err), eerr);
    endtask

    // Issue one request from IDLE, measure accept-to-out_valid edges.
    task automatic send(input int x, input int y, output int lat);
        @(negedge clk);
        angle_x  = W'(x);
        angle_y  = W'(y);
        in_valid = 1'b1;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic run(input int x, input int y, input int exp_lat,
                       input int ex, input int ey, input int ez,
                       input int ehx, input int ehy, input int eerr);
        int lat;
        send(x, y, lat);
        chk("latency", lat, exp_lat);
        chk_vec(ex, ey, ez, ehx, ehy, eerr);
        @(posedge clk);
        #1 chk("out_valid_after_hs", int'(out_valid), 0);
    endtask

    initial begin
        int lat;
        int stray;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        angle_x   = '0;
        angle_y   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_state", int'(state_dbg), int'(IDLE));
        chk_vec(0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk("in_ready_after_rst", int'(in_ready), 1);

        // Main function
        run(0, 0, LAT, 225, 0, 0, 225, 0, 0);
        run(45, 45, LAT, 112, 112, 159, 159, 159, 0);
        run(135, 45, LAT, -112, 112, 159, -159, 159, 0);
        run(-90, 100, LAT, 0, -4, 225, 0, -225, 0);
        // yaw 400 wraps to 40; pitch -30 reads sin=-112.5 rounded to -113
        run(400, -30, LAT, 149, 125, -113, 172, 145, 0);
        run(1000, 0, 2, 0, 0, 0, 0, 0, 1);
        // lower wrap boundary and negative pitch clamp
        run(-360, -100, LAT, 4, 0, -225, 225, 0, 0);
        run(720, 0, 2, 0, 0, 0, 0, 0, 1);
        run(-361, 0, 2, 0, 0, 0, 0, 0, 1);
        run(359, 0, LAT, 225, -4, 0, 225, -4, 0);

        // Stall: result held while out_ready is low
        out_ready = 1'b0;
        send(45, 45, lat);
        chk("stall_latency", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_rel_x", int'(lookat_rel_x), 112);
            chk("stall_rel_z", int'(lookat_rel_z), 159);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_hs_out_valid", int'(out_valid), 0);
        chk("hold_rel_x", int'(lookat_rel_x), 112);
        chk("hold_h_rel_y", int'(lookat_h_rel_y), 159);

        // Reset in the middle of DIV_X
        @(negedge clk);
        angle_x  = W'(0);
        angle_y  = W'(0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("mid_state", int'(state_dbg), int'(DIV_X));
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk_vec(0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk("mid_in_ready_after_rst", int'(in_ready), 1);
        stray = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1 if (out_valid) stray++;
        end
        chk("no_stale_out_valid", stray, 0);
        chk("idle_after_mid_rst", int'(state_dbg), int'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
